// File: rtl/neighbor_builder_if.sv
// Object-RAM and neighbor-RAM ports of the neighbor table builder.
// The builder is the master; the RAM side is the slave.
interface neighbor_builder_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  RAM_OBJ_EN;
  logic [ADDR_WIDTH-1:0] RAM_OBJ_A;
  logic [3:0]            RAM_OBJ_WE;
  logic [31:0]           RAM_OBJ_Di;
  logic [31:0]           RAM_OBJ_Do;
  logic                  RAM_NBR_EN;
  logic [ADDR_WIDTH-1:0] RAM_NBR_A;
  logic [3:0]            RAM_NBR_WE;
  logic [31:0]           RAM_NBR_Di;
  logic [31:0]           RAM_NBR_Do;

  modport master (
    output RAM_OBJ_EN, RAM_OBJ_A, RAM_OBJ_WE, RAM_OBJ_Di,
    output RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE, RAM_NBR_Di,
    input  RAM_OBJ_Do, RAM_NBR_Do
  );

  modport slave (
    input  RAM_OBJ_EN, RAM_OBJ_A, RAM_OBJ_WE, RAM_OBJ_Di,
    input  RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE, RAM_NBR_Di,
    output RAM_OBJ_Do, RAM_NBR_Do
  );
endinterface

// File: rtl/neighbor_builder.sv
// Builds per-vertex neighbor lists from the face list in object RAM.
// Each vertex slot holds a count word followed by neighbor indices in insertion order.
module neighbor_builder #(
  parameter int ADDR_WIDTH         = 11,
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               vertex_count,
  input  logic [31:0]               face_count,
  neighbor_builder_if.master        ram,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      index_err
);

  localparam logic [31:0] MAX_C   = 32'(MAX_NEIGHBOR_COUNT);
  localparam logic [31:0] LIMIT_C = MAX_C - 32'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FACE, S_FETCH, S_EDGE, S_RD_CNT,
    S_SCAN, S_CHECK, S_APP1, S_APP2, S_NEXT_FACE, S_DONE
  } state_t;

  state_t                state_r;
  logic [1:0]            ph_r;
  logic [31:0]           v_r, f_r, clear_k_r, face_r, obj_base_r;
  logic [31:0]           a_r, b_r, c_r, n_r, scan_i_r;
  logic [2:0]            edge_r;
  logic                  obj_en_r, nbr_en_r;
  logic [ADDR_WIDTH-1:0] obj_a_r, nbr_a_r;
  logic [3:0]            nbr_we_r;
  logic [31:0]           nbr_di_r;
  logic                  busy_r, done_r, overflow_r, index_err_r;
  logic [31:0]           u_s, w_s, base_s;

  function automatic logic idx_bad(input logic [31:0] x, input logic [31:0] v);
    return (x == 32'd0) || (x > v);
  endfunction

  // Directed edge u->w for the current edge slot: ab, ba, bc, cb, ca, ac.
  always_comb begin
    u_s = a_r;
    w_s = b_r;
    case (edge_r)
      3'd0:    begin u_s = a_r; w_s = b_r; end
      3'd1:    begin u_s = b_r; w_s = a_r; end
      3'd2:    begin u_s = b_r; w_s = c_r; end
      3'd3:    begin u_s = c_r; w_s = b_r; end
      3'd4:    begin u_s = c_r; w_s = a_r; end
      3'd5:    begin u_s = a_r; w_s = c_r; end
      default: begin u_s = a_r; w_s = b_r; end
    endcase
  end

  assign base_s = (u_s - 32'd1) * MAX_C;

  assign ram.RAM_OBJ_EN = obj_en_r;
  assign ram.RAM_OBJ_A  = obj_a_r;
  assign ram.RAM_OBJ_WE = 4'b0000;
  assign ram.RAM_OBJ_Di = 32'd0;
  assign ram.RAM_NBR_EN = nbr_en_r;
  assign ram.RAM_NBR_A  = nbr_a_r;
  assign ram.RAM_NBR_WE = nbr_we_r;
  assign ram.RAM_NBR_Di = nbr_di_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign overflow       = overflow_r;
  assign index_err      = index_err_r;

  // Build sequencer; RAM reads are issued then consumed two edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ph_r        <= 2'd0;
      v_r         <= 32'd0;
      f_r         <= 32'd0;
      clear_k_r   <= 32'd0;
      face_r      <= 32'd0;
      obj_base_r  <= 32'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      c_r         <= 32'd0;
      n_r         <= 32'd0;
      scan_i_r    <= 32'd0;
      edge_r      <= 3'd0;
      obj_en_r    <= 1'b0;
      obj_a_r     <= '0;
      nbr_en_r    <= 1'b0;
      nbr_a_r     <= '0;
      nbr_we_r    <= 4'b0000;
      nbr_di_r    <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
      index_err_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          obj_en_r <= 1'b0;
          nbr_en_r <= 1'b0;
          nbr_we_r <= 4'b0000;
          done_r   <= 1'b0;
          if (start) begin
            overflow_r  <= 1'b0;
            index_err_r <= 1'b0;
            busy_r      <= 1'b1;
            v_r         <= vertex_count;
            f_r         <= face_count;
            face_r      <= 32'd0;
            obj_base_r  <= vertex_count * 32'd3 + 32'd1;
            if (vertex_count == 32'd0) begin
              state_r <= S_FACE;
            end else begin
              clear_k_r <= 32'd1;
              nbr_en_r  <= 1'b1;
              nbr_we_r  <= 4'b1111;
              nbr_a_r   <= '0;
              nbr_di_r  <= 32'd0;
              state_r   <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          if (clear_k_r >= v_r) begin
            nbr_en_r <= 1'b0;
            nbr_we_r <= 4'b0000;
            state_r  <= S_FACE;
          end else begin
            clear_k_r <= clear_k_r + 32'd1;
            nbr_a_r   <= ADDR_WIDTH'(clear_k_r * MAX_C);
          end
        end
        S_FACE: begin
          if (face_r == f_r) begin
            state_r <= S_DONE;
          end else begin
            obj_en_r <= 1'b1;
            obj_a_r  <= ADDR_WIDTH'(obj_base_r);
            ph_r     <= 2'd0;
            state_r  <= S_FETCH;
          end
        end
        S_FETCH: begin
          case (ph_r)
            2'd0: begin
              obj_a_r <= ADDR_WIDTH'(obj_base_r + 32'd1);
              ph_r    <= 2'd1;
            end
            2'd1: begin
              a_r     <= ram.RAM_OBJ_Do;
              obj_a_r <= ADDR_WIDTH'(obj_base_r + 32'd2);
              ph_r    <= 2'd2;
            end
            2'd2: begin
              b_r      <= ram.RAM_OBJ_Do;
              obj_en_r <= 1'b0;
              ph_r     <= 2'd3;
            end
            default: begin
              c_r    <= ram.RAM_OBJ_Do;
              edge_r <= 3'd0;
              if (idx_bad(a_r, v_r) || idx_bad(b_r, v_r) || idx_bad(ram.RAM_OBJ_Do, v_r)) begin
                index_err_r <= 1'b1;
                state_r     <= S_NEXT_FACE;
              end else begin
                state_r <= S_EDGE;
              end
            end
          endcase
        end
        S_EDGE: begin
          if (edge_r == 3'd6) begin
            state_r <= S_NEXT_FACE;
          end else if (u_s == w_s) begin
            edge_r <= edge_r + 3'd1;
          end else begin
            nbr_en_r <= 1'b1;
            nbr_we_r <= 4'b0000;
            nbr_a_r  <= ADDR_WIDTH'(base_s);
            ph_r     <= 2'd0;
            state_r  <= S_RD_CNT;
          end
        end
        S_RD_CNT: begin
          if (ph_r == 2'd0) begin
            nbr_en_r <= 1'b0;
            ph_r     <= 2'd1;
          end else begin
            n_r      <= ram.RAM_NBR_Do;
            scan_i_r <= 32'd1;
            if (ram.RAM_NBR_Do == 32'd0) begin
              state_r <= S_CHECK;
            end else begin
              nbr_en_r <= 1'b1;
              nbr_a_r  <= ADDR_WIDTH'(base_s + 32'd1);
              ph_r     <= 2'd0;
              state_r  <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (ph_r == 2'd0) begin
            nbr_en_r <= 1'b0;
            ph_r     <= 2'd1;
          end else if (ram.RAM_NBR_Do == w_s) begin
            edge_r  <= edge_r + 3'd1;
            state_r <= S_EDGE;
          end else if (scan_i_r >= n_r) begin
            state_r <= S_CHECK;
          end else begin
            scan_i_r <= scan_i_r + 32'd1;
            nbr_en_r <= 1'b1;
            nbr_a_r  <= ADDR_WIDTH'(base_s + scan_i_r + 32'd1);
            ph_r     <= 2'd0;
          end
        end
        S_CHECK: begin
          if (n_r >= LIMIT_C) begin
            overflow_r <= 1'b1;
            edge_r     <= edge_r + 3'd1;
            state_r    <= S_EDGE;
          end else begin
            nbr_en_r <= 1'b1;
            nbr_we_r <= 4'b1111;
            nbr_a_r  <= ADDR_WIDTH'(base_s + n_r + 32'd1);
            nbr_di_r <= w_s;
            state_r  <= S_APP1;
          end
        end
        S_APP1: begin
          // Count is bumped only after the neighbor word lands.
          nbr_a_r  <= ADDR_WIDTH'(base_s);
          nbr_di_r <= n_r + 32'd1;
          state_r  <= S_APP2;
        end
        S_APP2: begin
          nbr_en_r <= 1'b0;
          nbr_we_r <= 4'b0000;
          edge_r   <= edge_r + 3'd1;
          state_r  <= S_EDGE;
        end
        S_NEXT_FACE: begin
          face_r     <= face_r + 32'd1;
          obj_base_r <= obj_base_r + 32'd3;
          state_r    <= S_FACE;
        end
        S_DONE: begin
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          obj_en_r <= 1'b0;
          nbr_en_r <= 1'b0;
          nbr_we_r <= 4'b0000;
          state_r  <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_builder.sv
// Randomized and directed bench for neighbor_builder: two instances (slot sizes 10 and 4)
// share stimulus and are checked against a list-based model of the neighbor table.
module tb_neighbor_builder;
  localparam int AW = 11;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] vertex_count, face_count;
  logic        busy0, done0, overflow0, index_err0;
  logic        busy1, done1, overflow1, index_err1;
  logic        rs_q = 1'b0, st_q = 1'b0, scramble;
  bit          eb0 = 0, eb1 = 0, pd0 = 0, pd1 = 0;

  logic [31:0] obj_mem [0:2047];
  logic [31:0] nbr0 [0:2047];
  logic [31:0] nbr1 [0:2047];

  int n_checks = 0, n_fail = 0;
  int mx [2] = '{10, 4};
  int fc [16][3];
  int exp_cnt [2][16];
  int exp_nb [2][16][10];
  bit exp_ovf [2], exp_ierr [2];
  int wr_cnt [2], wr_bad [2];
  int c0, c1, s2c0, s2c1;

  always #5 clk = ~clk;

  neighbor_builder_if #(.ADDR_WIDTH(AW)) bus0 ();
  neighbor_builder_if #(.ADDR_WIDTH(AW)) bus1 ();

  neighbor_builder #(.ADDR_WIDTH(AW), .MAX_NEIGHBOR_COUNT(10)) dut0 (
    .clk(clk), .rst(rst), .start(start), .vertex_count(vertex_count), .face_count(face_count),
    .ram(bus0), .busy(busy0), .done(done0), .overflow(overflow0), .index_err(index_err0));

  neighbor_builder #(.ADDR_WIDTH(AW), .MAX_NEIGHBOR_COUNT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .vertex_count(vertex_count), .face_count(face_count),
    .ram(bus1), .busy(busy1), .done(done1), .overflow(overflow1), .index_err(index_err1));

  // Synchronous RAMs; scramble fills neighbor RAM with junk between builds.
  always @(posedge clk) begin
    if (scramble) begin
      for (int a = 0; a < 2048; a++) begin
        nbr0[a] <= $urandom;
        nbr1[a] <= $urandom;
      end
    end else begin
      if (bus0.RAM_OBJ_EN) bus0.RAM_OBJ_Do <= obj_mem[bus0.RAM_OBJ_A];
      if (bus1.RAM_OBJ_EN) bus1.RAM_OBJ_Do <= obj_mem[bus1.RAM_OBJ_A];
      if (bus0.RAM_NBR_EN) begin
        if (bus0.RAM_NBR_WE == 4'hF) nbr0[bus0.RAM_NBR_A] <= bus0.RAM_NBR_Di;
        bus0.RAM_NBR_Do <= nbr0[bus0.RAM_NBR_A];
      end
      if (bus1.RAM_NBR_EN) begin
        if (bus1.RAM_NBR_WE == 4'hF) nbr1[bus1.RAM_NBR_A] <= bus1.RAM_NBR_Di;
        bus1.RAM_NBR_Do <= nbr1[bus1.RAM_NBR_A];
      end
    end
  end

  always @(posedge clk) begin
    rs_q <= rst;
    st_q <= start;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle protocol check of one instance; e_in/e_out is the expected busy level.
  task automatic mon(input string nm, input logic bsy, input logic dn, input logic ov, input logic ie,
                     input logic oen, input logic [AW-1:0] oa, input logic [3:0] owe, input logic [31:0] odi,
                     input logic nen, input logic [AW-1:0] na, input logic [3:0] nwe, input logic [31:0] ndi,
                     input bit e_in, input bit pd, output bit e_out);
    e_out = e_in;
    chk({nm, "_obj_we_zero"}, longint'(owe), 0);
    chk({nm, "_obj_di_zero"}, longint'(odi), 0);
    if (rs_q) begin
      e_out = 0;
      chk({nm, "_rst_flags"}, longint'({bsy, dn, ov, ie, oen, nen}), 0);
      chk({nm, "_rst_addr"}, longint'({oa, na, nwe}), 0);
      chk({nm, "_rst_di"}, longint'(ndi), 0);
    end else begin
      if (dn) begin
        chk({nm, "_done_after_busy"}, longint'(e_in), 1);
        chk({nm, "_busy_low_at_done"}, longint'(bsy), 0);
        chk({nm, "_done_one_cycle"}, longint'(pd), 0);
        e_out = 0;
      end else begin
        if (!e_in && st_q) e_out = 1;
        chk({nm, "_busy"}, longint'(bsy), longint'(e_out));
      end
      chk({nm, "_nbr_we_legal"}, longint'((nwe == 4'h0) || (nwe == 4'hF)), 1);
      if (nwe == 4'hF) chk({nm, "_write_in_run"}, longint'(nen && e_out), 1);
    end
  endtask

  // Compare process: checks both instances on every cycle.
  always @(negedge clk) begin
    bit n0, n1;
    mon("d0", busy0, done0, overflow0, index_err0, bus0.RAM_OBJ_EN, bus0.RAM_OBJ_A, bus0.RAM_OBJ_WE,
        bus0.RAM_OBJ_Di, bus0.RAM_NBR_EN, bus0.RAM_NBR_A, bus0.RAM_NBR_WE, bus0.RAM_NBR_Di, eb0, pd0, n0);
    mon("d1", busy1, done1, overflow1, index_err1, bus1.RAM_OBJ_EN, bus1.RAM_OBJ_A, bus1.RAM_OBJ_WE,
        bus1.RAM_OBJ_Di, bus1.RAM_NBR_EN, bus1.RAM_NBR_A, bus1.RAM_NBR_WE, bus1.RAM_NBR_Di, eb1, pd1, n1);
    eb0 = n0;
    eb1 = n1;
    pd0 = done0;
    pd1 = done1;
  end

  task automatic set_face(input int i, input int a, input int b, input int c);
    fc[i][0] = a;
    fc[i][1] = b;
    fc[i][2] = c;
  endtask

  task automatic load(input int v, input int f);
    for (int a = 0; a < 2048; a++) obj_mem[a] = $urandom;
    for (int i = 0; i < f; i++)
      for (int j = 0; j < 3; j++) obj_mem[3 * v + 1 + 3 * i + j] = fc[i][j];
    @(negedge clk); scramble = 1'b1;
    @(negedge clk); scramble = 1'b0;
  endtask

  // Reference: neighbor lists as plain arrays, edges in order ab, ba, bc, cb, ca, ac.
  task automatic model(input int v, input int f);
    int us [6];
    int ws [6];
    for (int i = 0; i < 2; i++) begin
      exp_ovf[i] = 0;
      exp_ierr[i] = 0;
      for (int k = 0; k < 16; k++) exp_cnt[i][k] = 0;
    end
    for (int fi = 0; fi < f; fi++) begin
      int a, b, c;
      a = fc[fi][0]; b = fc[fi][1]; c = fc[fi][2];
      if (a < 1 || a > v || b < 1 || b > v || c < 1 || c > v) begin
        exp_ierr[0] = 1;
        exp_ierr[1] = 1;
      end else begin
        us = '{a, b, b, c, c, a};
        ws = '{b, a, c, b, a, c};
        for (int i = 0; i < 2; i++) begin
          for (int e = 0; e < 6; e++) begin
            int u, w;
            bit seen;
            u = us[e]; w = ws[e]; seen = 0;
            if (u != w) begin
              for (int j = 0; j < exp_cnt[i][u]; j++) if (exp_nb[i][u][j] == w) seen = 1;
              if (!seen) begin
                if (exp_cnt[i][u] >= mx[i] - 1) exp_ovf[i] = 1;
                else begin
                  exp_nb[i][u][exp_cnt[i][u]] = w;
                  exp_cnt[i][u]++;
                end
              end
            end
          end
        end
      end
    end
  endtask

  task automatic run_build(input int v, input int f, input int poke_at, output int cyc0, output int cyc1);
    bit d0, d1;
    int c;
    vertex_count = v;
    face_count = f;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    d0 = 0; d1 = 0; c = 1; cyc0 = 0; cyc1 = 0;
    wr_cnt = '{0, 0};
    wr_bad = '{0, 0};
    while (!(d0 && d1) && c < 8000) begin
      if (bus0.RAM_NBR_WE == 4'hF) begin
        wr_cnt[0]++;
        if (bus0.RAM_NBR_Di != 0 || (int'(bus0.RAM_NBR_A) % mx[0]) != 0) wr_bad[0]++;
      end
      if (bus1.RAM_NBR_WE == 4'hF) begin
        wr_cnt[1]++;
        if (bus1.RAM_NBR_Di != 0 || (int'(bus1.RAM_NBR_A) % mx[1]) != 0) wr_bad[1]++;
      end
      if (done0 && !d0) begin d0 = 1; cyc0 = c; end
      if (done1 && !d1) begin d1 = 1; cyc1 = c; end
      start = (c == poke_at);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("run_completed", longint'(d0 && d1), 1);
  endtask

  task automatic check_all(input string tag, input int v);
    for (int i = 0; i < 2; i++) begin
      for (int k = 1; k <= v; k++) begin
        int base, got;
        base = (k - 1) * mx[i];
        got = (i == 0) ? nbr0[base] : nbr1[base];
        chk($sformatf("%s_i%0d_v%0d_count", tag, i, k), got, exp_cnt[i][k]);
        for (int j = 0; j < exp_cnt[i][k] && j < 10; j++) begin
          got = (i == 0) ? nbr0[base + 1 + j] : nbr1[base + 1 + j];
          chk($sformatf("%s_i%0d_v%0d_nb%0d", tag, i, k, j), got, exp_nb[i][k][j]);
        end
      end
    end
    chk({tag, "_overflow0"}, longint'(overflow0), longint'(exp_ovf[0]));
    chk({tag, "_overflow1"}, longint'(overflow1), longint'(exp_ovf[1]));
    chk({tag, "_index_err0"}, longint'(index_err0), longint'(exp_ierr[0]));
    chk({tag, "_index_err1"}, longint'(index_err1), longint'(exp_ierr[1]));
  endtask

  task automatic scenario(input string tag, input int v, input int f, input int poke, output int r0, output int r1);
    load(v, f);
    model(v, f);
    run_build(v, f, poke, r0, r1);
    check_all(tag, v);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vertex_count = 0; face_count = 0; scramble = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", longint'({busy0, done0, overflow0, index_err0, busy1, done1, overflow1, index_err1,
        bus0.RAM_OBJ_EN, bus0.RAM_NBR_EN, bus0.RAM_NBR_WE}), 0);
    rst = 1'b0;

    // Single triangle
    set_face(0, 1, 2, 3);
    scenario("s1", 3, 1, -1, c0, c1);
    chk("s1_model_pin_v3", longint'({exp_cnt[0][3], exp_nb[0][3][0], exp_nb[0][3][1]}), longint'({32'd2, 32'd2, 32'd1}));
    chk("s1_lit_v1", longint'({nbr0[0], nbr0[1], nbr0[2]}), longint'({32'd2, 32'd2, 32'd3}));
    chk("s1_lit_v3", longint'({nbr0[20], nbr0[21], nbr0[22]}), longint'({32'd2, 32'd2, 32'd1}));

    // Fan overflow on the 4-word slot instance
    set_face(0, 1, 2, 3); set_face(1, 1, 3, 4); set_face(2, 1, 4, 5); set_face(3, 1, 5, 6);
    scenario("s3", 6, 4, -1, c0, c1);
    chk("s3_lit_v1", longint'({nbr1[0], nbr1[1], nbr1[2], nbr1[3]}), longint'({32'd3, 32'd2, 32'd3, 32'd4}));
    chk("s3_lit_flags", longint'({overflow1, index_err1, overflow0}), longint'({1'b1, 1'b0, 1'b0}));

    // Shared edge; start must clear the overflow left by the fan run
    set_face(0, 1, 2, 3); set_face(1, 1, 3, 4);
    scenario("s2", 4, 2, -1, s2c0, s2c1);
    chk("s2_model_pin_v1", longint'({exp_cnt[0][1], exp_nb[0][1][2]}), longint'({32'd3, 32'd4}));
    chk("s2_lit_v3", longint'({nbr0[20], nbr0[21], nbr0[22], nbr0[23]}), longint'({32'd3, 32'd2, 32'd1, 32'd4}));
    chk("s2_flags_cleared", longint'({overflow1, index_err1}), 0);

    // Degenerate and out-of-range faces
    set_face(0, 1, 1, 2); set_face(1, 0, 2, 3);
    scenario("s4", 3, 2, -1, c0, c1);
    chk("s4_lit", longint'({nbr0[0], nbr0[1], nbr0[10], nbr0[11], nbr0[20]}),
        longint'({32'd1, 32'd2, 32'd1, 32'd1, 32'd0}));
    chk("s4_index_err_lit", longint'(index_err0), 1);

    // Reset mid-scan with start held during reset, then a clean rebuild
    set_face(0, 1, 2, 3); set_face(1, 1, 3, 4);
    load(4, 2);
    model(4, 2);
    vertex_count = 4; face_count = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      int c;
      c = 0;
      while (!(bus0.RAM_NBR_EN && bus0.RAM_NBR_WE == 4'h0 && (int'(bus0.RAM_NBR_A) % 10) != 0) && c < 3000) begin
        @(negedge clk);
        c++;
      end
      chk("s5_scan_reached", longint'(c < 3000), 1);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    chk("s5_outputs_zero", longint'({busy0, done0, overflow0, index_err0, busy1, bus0.RAM_NBR_EN, bus0.RAM_NBR_WE}), 0);
    @(negedge clk);
    chk("s5_start_in_rst_ignored", longint'({busy0, busy1}), 0);
    run_build(4, 2, -1, c0, c1);
    check_all("s5", 4);
    chk("s5_cycles0", c0, s2c0);
    chk("s5_cycles1", c1, s2c1);

    // No faces: only the count words are cleared
    load(3, 0);
    model(3, 0);
    run_build(3, 0, -1, c0, c1);
    check_all("s6a", 3);
    chk("s6a_writes0", wr_cnt[0], 3);
    chk("s6a_writes1", wr_cnt[1], 3);
    chk("s6a_bad_writes", wr_bad[0] + wr_bad[1], 0);

    // Extra start while busy changes neither result nor cycle count
    set_face(0, 1, 2, 3); set_face(1, 1, 3, 4);
    scenario("s6b", 4, 2, 10, c0, c1);
    chk("s6b_cycles0", c0, s2c0);
    chk("s6b_cycles1", c1, s2c1);

    // Random meshes
    for (int it = 0; it < 14; it++) begin
      int v, f;
      v = $urandom_range(1, 12);
      f = $urandom_range(0, 8);
      for (int i = 0; i < f; i++)
        for (int j = 0; j < 3; j++)
          fc[i][j] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, v + 1) : $urandom_range(1, v);
      scenario($sformatf("rnd%0d", it), v, f, ($urandom_range(0, 1) == 1) ? 8 : -1, c0, c1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neighbor_builder.md
Name: neighbor_builder

Overview:
Builds the neighbor table that the smoothing stage consumes. After `start`, it clears the per-vertex count words in neighbor RAM. It then walks every face in object RAM and inserts each undirected edge into the neighbor lists of both endpoints, skipping duplicates.
It is the writer side of the neighbor-RAM format and runs before the averaging pass in the subdivision pipeline.

Parameters:
ADDR_WIDTH, 11, address width of both RAM ports.
MAX_NEIGHBOR_COUNT, 10, words per vertex slot in neighbor RAM: 1 count word plus up to MAX_NEIGHBOR_COUNT-1 neighbor indices.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a build; sampled only in IDLE.
vertex_count  in  32  number of vertices V.
face_count  in  32  number of faces F.
RAM_OBJ_Do  in  32  object RAM read data.
RAM_NBR_Do  in  32  neighbor RAM read data.
RAM_OBJ_EN  out  1  object RAM enable.
RAM_OBJ_A  out  ADDR_WIDTH  object RAM address.
RAM_OBJ_WE  out  4  object RAM write enables; always 0.
RAM_OBJ_Di  out  32  object RAM write data; always 0.
RAM_NBR_EN  out  1  neighbor RAM enable.
RAM_NBR_A  out  ADDR_WIDTH  neighbor RAM address.
RAM_NBR_WE  out  4  neighbor RAM write enables; 4'b1111 or 0.
RAM_NBR_Di  out  32  neighbor RAM write data.
busy  out  1  high from the cycle after start is accepted until DONE.
done  out  1  one-cycle pulse at completion.
overflow  out  1  sticky: an insert was dropped because the slot was full; cleared on accept of start.
index_err  out  1  sticky: a face index was 0 or greater than V; cleared on accept of start.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. rst overrides start.
- Reset values: state=IDLE; every output 0.
- RAM model: synchronous read. Do reflects the address presented at the previous rising edge (1-cycle latency). A write occurs at the rising edge while EN=1 and WE=4'b1111.
- Object RAM layout: address 0 is the header. Vertices occupy 1..3V. Face f (0-based), corner j, is at 3V+1+3f+j and holds a 1-based vertex index.
- Neighbor RAM layout: vertex k (1-based) has slot base (k-1)*MAX_NEIGHBOR_COUNT.
  - Word base+0 holds count n.
  - Words base+1..base+n hold 1-based neighbor indices in insertion order.
- Address arithmetic: computed in 32 bits, truncated to ADDR_WIDTH.
- IDLE: EN=0, WE=0. When start=1, clear overflow and index_err, set busy, and go to CLEAR.
- CLEAR: one write per cycle of 0 to base+0 for k=1..V. V=0 skips this state. Then go to FETCH.
- FETCH:
  - Read the 3 corner words a, b, c of the current face, pipelined over 4 cycles.
  - If any corner is 0 or greater than V: set index_err, skip the face, go to NEXT_FACE.
  - Otherwise process 6 directed edges in fixed order: a→b, b→a, b→c, c→b, c→a, a→c.
- Directed edge u→w:
  - If u==w, skip it.
  - RD_CNT: read base(u)+0 to get n.
  - SCAN: read base(u)+1..base(u)+n, comparing each word with w. On a match, the edge is done with no write. n=0 goes straight to the insert check.
  - Insert check: if n ≥ MAX_NEIGHBOR_COUNT-1, set overflow and drop the edge. Otherwise run APPEND.
  - APPEND, cycle 1: write w to base(u)+n+1.
  - APPEND, cycle 2: write n+1 to base(u)+0.
- NEXT_FACE: increment the face index. When it reaches F, go to DONE; otherwise go to FETCH. F=0 goes from CLEAR directly to DONE.
- DONE: one cycle. Assert done, clear busy and all EN/WE, return to IDLE.
- start while busy: ignored.
- rst mid-build: return to IDLE within that edge with outputs zeroed. Neighbor RAM contents are then undefined and a fresh start is required.
- No write hazards: a read never targets a word written in the same cycle, because the count is re-read per edge after the append completes.

Test Plan:
1. Single triangle: V=3, F=1, face (1,2,3).
   - Slots: v1=[2: 2,3], v2=[2: 1,3], v3=[2: 2,1].
   - busy for the whole run, then done high for exactly 1 cycle.
2. Shared edge: V=4, F=2, faces (1,2,3) and (1,3,4).
   - Slots: v1=[3: 2,3,4], v2=[2: 1,3], v3=[3: 2,1,4], v4=[2: 3,1].
   - No duplicate entries.
3. Fan overflow: MAX_NEIGHBOR_COUNT=4, V=6, faces (1,2,3),(1,3,4),(1,4,5),(1,5,6).
   - v1 count stays 3 with [2,3,4].
   - overflow=1, index_err=0.
4. Degenerate and bad faces: V=3, F=2, faces (1,1,2) and (0,2,3).
   - v1=[1: 2], v2=[1: 1], v3 count=0.
   - index_err=1.
5. Reset and restart: assert rst for 1 cycle mid-SCAN.
   - All outputs 0 next cycle; start during rst is ignored.
   - A subsequent start reproduces the scenario 2 result exactly, with overflow and index_err cleared.
6. Edge cases:
   - V=3, F=0: exactly 3 CLEAR writes of 0, then done.
   - A second start pulse while busy has no effect on the result or the cycle count.
